// File: rtl/shift_reg_pkg.sv
// Shared mode encoding and sizing helper for the universal shift register.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_t;

  // Counter must be able to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int countWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_cell.sv
// One bit of the universal shift register: 4:1 next-state mux feeding a
// flip-flop with asynchronous active-low reset to a per-bit reset value.
module shift_cell
  import shift_reg_pkg::*;
(
  input  logic        CLK,
  input  logic        n_Reset,
  input  logic        clr,
  input  shift_mode_t mode,
  input  logic        i_loadBit,
  input  logic        i_leftBit,
  input  logic        i_rightBit,
  input  logic        i_resetBit,
  output logic        o_q
);

  logic r_q;
  logic w_next;

  // Shift left pulls from the lower-index neighbour, shift right from the higher one.
  always_comb begin
    w_next = r_q;
    case (mode)
      MODE_HOLD: w_next = r_q;
      MODE_SHL:  w_next = i_rightBit;
      MODE_SHR:  w_next = i_leftBit;
      MODE_LOAD: w_next = i_loadBit;
      default:   w_next = r_q;
    endcase
  end

  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      r_q <= i_resetBit;
    end else if (clr) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift left / shift right / load, with a
// saturating shift counter and done pulse. Rotation is added by SHIFT_ROTATE_EN.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                            CLK,
  input  logic                            n_Reset,
  input  logic                            clr,
  input  logic [1:0]                      mode,
  input  logic [WIDTH-1:0]                D,
  input  logic                            sin_l,
  input  logic                            sin_r,
  output logic [WIDTH-1:0]                Q,
  output logic                            sout_l,
  output logic                            sout_r,
  output logic [countWidth(WIDTH)-1:0]    count,
  output logic                            done
`ifdef SHIFT_ROTATE_EN
  ,
  input  logic                            rot
`endif
);

  localparam int CW = countWidth(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  shift_mode_t      w_mode;
  logic [WIDTH-1:0] w_q;
  logic             w_msbIn;
  logic             w_lsbIn;
  logic [CW-1:0]    r_count;
  logic             r_done;

  assign w_mode = shift_mode_t'(mode);

  // Rotation simply feeds the opposite end back in place of the serial input.
`ifdef SHIFT_ROTATE_EN
  assign w_msbIn = rot ? w_q[0]       : sin_l;
  assign w_lsbIn = rot ? w_q[WIDTH-1] : sin_r;
`else
  assign w_msbIn = sin_l;
  assign w_lsbIn = sin_r;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_left;
    logic w_right;

    if (i == WIDTH - 1) begin : g_msb
      assign w_left = w_msbIn;
    end else begin : g_inner_l
      assign w_left = w_q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign w_right = w_lsbIn;
    end else begin : g_inner_r
      assign w_right = w_q[i-1];
    end

    shift_cell u_cell (
      .CLK        (CLK),
      .n_Reset    (n_Reset),
      .clr        (clr),
      .mode       (w_mode),
      .i_loadBit  (D[i]),
      .i_leftBit  (w_left),
      .i_rightBit (w_right),
      .i_resetBit (RESET_VAL[i]),
      .o_q        (w_q[i])
    );
  end

  // done fires only on the WIDTH-1 -> WIDTH transition; saturated shifts keep it low.
  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      case (w_mode)
        MODE_SHL, MODE_SHR: begin
          if (r_count != FULL) begin
            r_count <= r_count + 1'b1;
          end
          r_done <= (r_count == LAST);
        end
        MODE_LOAD: begin
          r_count <= '0;
          r_done  <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign Q      = w_q;
  assign sout_l = w_q[WIDTH-1];
  assign sout_r = w_q[0];
  assign count  = r_count;
  assign done   = r_done;

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register. Successor to the single-bit D flip-flop: WIDTH bits, four operating modes and a shift counter.
- Modes are hold, shift left, shift right and parallel load. Serial ports sit at both ends.
- A shift counter reports when a full word has been shifted in or out.
- Used as a SPI/UART-style serialiser/deserialiser and as a general staging register in datapaths.

Parameters:
- WIDTH, 8: register width in bits. Must be ≥ 2.
- RESET_VAL, '0: value loaded into Q on asynchronous reset. WIDTH bits.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- n_Reset  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: Q ← 0, count ← 0.
- mode  input  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- D  input  WIDTH  parallel load data.
- sin_l  input  1  serial in for shift right; enters at MSB.
- sin_r  input  1  serial in for shift left; enters at LSB.
- Q  output  WIDTH  register contents.
- sout_l  output  1  Q[WIDTH-1], combinational from Q.
- sout_r  output  1  Q[0], combinational from Q.
- count  output  $clog2(WIDTH+1)  shifts since last load/clear/reset; saturates at WIDTH.
- done  output  1  one-cycle registered pulse when count reaches WIDTH.
- rot  input  1  rotate select; exists only with SHIFT_ROTATE_EN.

Behaviour:
- Reset (n_Reset=0, asynchronous, no clock needed): Q=RESET_VAL, count=0, done=0. Held while n_Reset=0. First update is on the first rising CLK edge after release.
- Reset mid-operation: shifting aborts immediately. No partial-count retention.
- Priority at each rising edge: clr > mode.
- clr=1: Q ← 0, count ← 0, done ← 0. mode is ignored.
- mode 00 (hold): Q and count unchanged; done ← 0.
- mode 01 (shift left): Q ← {Q[WIDTH-2:0], sin_r}.
- mode 10 (shift right): Q ← {sin_l, Q[WIDTH-1:1]}.
- Either shift mode: count ← min(count+1, WIDTH).
- mode 11 (load): Q ← D, count ← 0, done ← 0.
- done ← 1 only on the edge where count goes WIDTH-1 → WIDTH due to a shift. Otherwise done ← 0, so it never stays high two cycles.
- Further shifts at count=WIDTH keep count=WIDTH and done=0. Serial data continues shifting normally.
- Latency: Q, count and done update one cycle after the controlling inputs are sampled. sout_l/sout_r follow Q with zero latency.
- Inputs are sampled at the rising edge. Benches drive inputs on the falling edge and check shortly after the rising edge.
- No X propagation from unused inputs: D is ignored unless mode=11; sin_l/sin_r are ignored outside their shift mode.

Optional Feature:
- Macro: SHIFT_ROTATE_EN.
- Defined: port rot is present. When rot=1 in mode 01, Q ← {Q[WIDTH-2:0], Q[WIDTH-1]}. When rot=1 in mode 10, Q ← {Q[0], Q[WIDTH-1:1]}. Serial inputs are ignored; count and done behave exactly as for a normal shift. rot has no effect in modes 00/11 or during clr.
- Not defined: port rot is absent. Shifts always take the serial inputs.

Decomposition:
- Package shift_reg_pkg:
  - enum shift_mode_t: MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11.
  - localparam function for the count width.
- Sub-module shift_cell: one bit, a 4:1 next-state mux plus a flip-flop with async active-low reset.
  - Inputs: CLK, n_Reset, clr, mode, load bit, left neighbour, right neighbour, reset bit.
  - Instantiated WIDTH times in a generate loop.
- The counter and done logic live in the top module.

Test Plan (WIDTH=8, RESET_VAL=8'hA5):
- Assert n_Reset=0 mid-cycle, no clock edge → Q=8'hA5, count=0, done=0 within 1 time unit. Release; hold mode for 2 cycles → Q remains 8'hA5.
- mode=11, D=8'h3C → after one edge Q=8'h3C, count=0. mode=00 for 3 cycles → Q=8'h3C throughout.
- Load 8'h00, then mode=01 with sin_r = 1,0,1,1,0,0,1,0 on 8 edges → Q=8'hB2, count=8, done=1 on the 8th edge only. A 9th shift → count=8, done=0.
- Load 8'h81, mode=10, sin_l=0 → after edges Q = 8'h40, 8'h20; sout_r = 1 before the first edge, 0 after it.
- During a shift with count=5, set clr=1 together with mode=11 and D=8'hFF → Q=8'h00, count=0 (clr wins). Separately, pulse n_Reset low mid-shift → Q=8'hA5, count=0 immediately.
- With SHIFT_ROTATE_EN: load 8'h81, mode=01, rot=1, sin_r=0 → Q=8'h03, then 8'h06. After 8 rotates of 8'h81, Q=8'h81 and done=1.
